digit_increment_sequencer: RTL and testbench

//   Sequences BCD increments over a DIGITS-wide decimal counter through one shared

---
 rtl/digit_increment_sequencer.sv | 76 +++++++
 tb/tb_digit_increment_sequencer.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/digit_increment_sequencer.sv
// digit_increment_sequencer: masked BCD increment rippled one digit per cycle through a shared adder; define SATURATE_EN to clamp at 9...9 instead of wrapping
module digit_increment_sequencer #(
  parameter int DIGITS = 6,
  parameter int IDX_W  = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  inc_req,
  input  logic [DIGITS-1:0]     inc_mask,
  output logic                  busy,
  output logic                  done,
  output logic                  req_dropped,
  output logic                  overflow,
  output logic [4*DIGITS-1:0]   digits_out
);
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  state_t state, state_nx;
  logic [4*DIGITS-1:0] work, work_nx;
  logic [DIGITS-1:0] pend;
  logic [IDX_W-1:0] idx;
  logic cy, cout, last, start;
  logic [4:0] sum;
  // shared digit adder, next working value and next state
  always_comb begin
    sum = {1'b0, work[4*idx +: 4]} + 5'(pend[idx]) + 5'(cy);
    cout = sum >= 5'd10;
    last = idx == IDX_W'(DIGITS - 1);
    start = inc_req && |inc_mask;
    work_nx = work;
    work_nx[4*idx +: 4] = cout ? 4'(sum - 5'd10) : sum[3:0];
`ifdef SATURATE_EN
    if (last && cout) work_nx = {DIGITS{4'd9}};
`endif
    state_nx = clear ? IDLE :
               state == IDLE ? (start ? SCAN : IDLE) :
               state == SCAN ? (last ? DONE : SCAN) : IDLE;
    busy = state != IDLE;
    done = state == DONE;
  end
  // state, working digits and committed result; the final digit's edge commits so done and digits_out line up
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      work <= '0;
      digits_out <= '0;
      pend <= '0;
      idx <= '0;
      cy <= 1'b0;
      overflow <= 1'b0;
      req_dropped <= 1'b0;
    end else begin
      state <= state_nx;
      req_dropped <= inc_req && busy;
      if (clear) begin
        work <= '0;
        digits_out <= '0;
        pend <= '0;
        cy <= 1'b0;
        overflow <= 1'b0;
      end else if (state == IDLE && start) begin
        pend <= inc_mask;
        idx <= '0;
        cy <= 1'b0;
      end else if (state == SCAN) begin
        work <= work_nx;
        cy <= cout;
        idx <= last ? idx : idx + 1'b1;
        if (last) begin
          digits_out <= work_nx;
          overflow <= overflow | cout;
        end
      end
    end
  end
endmodule

// File: tb/tb_digit_increment_sequencer.sv
// tb_digit_increment_sequencer: random and directed increments scored against a decimal-arithmetic model
module tb_digit_increment_sequencer;
  localparam int D = 6;
  localparam int MAXV = 1000000;
  logic clk = 0, reset = 1, clear = 0, inc_req = 0;
  logic [D-1:0] inc_mask = '0;
  logic busy, done, req_dropped, overflow;
  logic [4*D-1:0] digits_out;
  typedef struct {int due; int val; logic ovf;} ent_t;
  ent_t sb[$];
  int drop_q[$], clr_q[$];
  int cyc = 0, errors = 0, checks = 0;
  int val = 0, busy_from = 1, busy_until = 0;
  logic ovf = 0, run = 0;
  int mv = 0;
  logic mo = 0;

  digit_increment_sequencer #(.DIGITS(D), .IDX_W(3)) dut (
    .clk(clk), .reset(reset), .clear(clear), .inc_req(inc_req), .inc_mask(inc_mask),
    .busy(busy), .done(done), .req_dropped(req_dropped), .overflow(overflow), .digits_out(digits_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [4*D-1:0] to_bcd(input int v);
    logic [4*D-1:0] r;
    r = '0;
    for (int i = 0; i < D; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic [D-1:0] m, input logic c);
    int add;
    inc_req = r;
    inc_mask = m;
    clear = c;
    if (c) begin
      val = 0;
      ovf = 0;
      while (sb.size() > 0 && sb[$].due > cyc) void'(sb.pop_back());
      clr_q.push_back(cyc + 1);
      if (busy_until > cyc) busy_until = cyc;
    end else if (r) begin
      if (cyc >= busy_from && cyc <= busy_until) drop_q.push_back(cyc + 1);
      else if (m != 0) begin
        add = 0;
        for (int i = 0; i < D; i++) if (m[i]) add += 10 ** i;
        val += add;
        if (val >= MAXV) begin
          ovf = 1;
`ifdef SATURATE_EN
          val = MAXV - 1;
`else
          val -= MAXV;
`endif
        end
        sb.push_back('{cyc + D + 1, val, ovf});
        busy_from = cyc + 1;
        busy_until = cyc + D + 1;
      end
    end
    @(posedge clk);
    #1;
    inc_req = 0;
    inc_mask = '0;
    clear = 0;
  endtask

  task automatic inc_wait(input logic [D-1:0] m);
    step(1, m, 0);
    repeat (D + 1) step(0, '0, 0);
  endtask

  // scoreboard monitor sampling on the falling edge
  always @(negedge clk) if (run) begin
    if (clr_q.size() > 0 && clr_q[0] == cyc) begin
      void'(clr_q.pop_front());
      mv = 0;
      mo = 0;
    end
    if (done) begin
      checks++;
      if (sb.size() == 0 || sb[0].due != cyc) begin
        errors++;
        $display("FAIL done_strobe cyc=%0d unexpected (queued=%0d due=%0d)", cyc, sb.size(), sb.size() ? sb[0].due : -1);
      end else begin
        mv = sb[0].val;
        mo = sb[0].ovf;
        void'(sb.pop_front());
      end
    end else if (sb.size() > 0 && sb[0].due <= cyc) begin
      checks++;
      errors++;
      $display("FAIL done_missing cyc=%0d got=0 want=1 (due %0d)", cyc, sb[0].due);
      void'(sb.pop_front());
    end
    chk("digits_out", 32'(digits_out), 32'(to_bcd(mv)));
    chk("overflow", 32'(overflow), 32'(mo));
    chk("busy", 32'(busy), 32'(cyc >= busy_from && cyc <= busy_until));
    if (req_dropped || (drop_q.size() > 0 && drop_q[0] == cyc)) begin
      chk("req_dropped", 32'(req_dropped), 32'(drop_q.size() > 0 && drop_q[0] == cyc));
      if (drop_q.size() > 0 && drop_q[0] == cyc) void'(drop_q.pop_front());
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_digits", 32'(digits_out), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_overflow", 32'(overflow), 32'h0);
    chk("rst_dropped", 32'(req_dropped), 32'h0);
    @(posedge clk);
    #1;
    reset = 0;
    run = 1;
    step(0, '0, 0);
    repeat (9) inc_wait(6'h01);
    inc_wait(6'h01);
    step(0, '0, 1);
    step(0, '0, 0);
    repeat (10) inc_wait(6'h03);
    step(0, '0, 1);
    step(0, '0, 0);
    repeat (9) inc_wait(6'h3f);
    inc_wait(6'h01);
    inc_wait(6'h01);
    step(0, '0, 1);
    step(0, '0, 0);
    step(1, 6'h01, 0);
    step(0, '0, 0);
    step(0, '0, 0);
    step(1, 6'h02, 0);
    repeat (6) step(0, '0, 0);
    step(1, 6'h00, 0);
    step(0, '0, 0);
    step(1, 6'h01, 0);
    step(0, '0, 0);
    step(0, '0, 0);
    step(0, '0, 1);
    repeat (3) step(0, '0, 0);
    inc_wait(6'h05);
    step(1, 6'h01, 0);
    step(0, '0, 0);
    step(0, '0, 0);
    val = 0;
    ovf = 0;
    sb.delete();
    drop_q.delete();
    clr_q.push_back(cyc);
    busy_until = cyc - 1;
    reset = 1;
    @(posedge clk);
    #1;
    reset = 0;
    repeat (3) step(0, '0, 0);
    for (int n = 0; n < 400; n++) begin
      logic c, r;
      c = $urandom_range(0, 39) == 0;
      r = !c && $urandom_range(0, 2) == 0;
      step(r, ($urandom_range(0, 5) == 0) ? 6'h00 : 6'($urandom), c);
    end
    repeat (D + 4) step(0, '0, 0);
    chk("sb_drained", 32'(sb.size()), 32'h0);
    run = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
